id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode (ID) stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage.
- Latches {instr, pc} from IF and decodes a fixed MIPS subset.
- Owns the 32x32 general register file: reads it here, writes it from the WB bus.
- Resolves branches/jumps back to IF via jump_bus; stalls on RAW hazards against EX/MEM/WB; emits a decoded bundle to EX.

Parameters:
- FS_TO_DS_BUS_WD, 64, {instr[63:32], pc[31:0]} from IF.
- DS_TO_ES_BUS_WD, 136, decoded bundle to EX (layout below).
- JUMP_BUS_WD, 33, {jump_taken, jump_target[31:0]} to IF.
- WS_TO_RF_BUS_WD, 38, {rf_we, rf_waddr[4:0], rf_wdata[31:0]} from WB.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- es_allowin  in  1  EX can accept this cycle.
- fs_to_ds_valid  in  1  IF bundle valid.
- fs_to_ds_bus  in  64  {instr, pc}.
- ds_allowin  out  1  ID can accept from IF.
- jump_bus  out  33  {taken, target}.
- ds_to_es_valid  out  1  bundle to EX valid.
- ds_to_es_bus  out  136  decoded bundle.
- ws_to_rf_bus  in  38  register-file write port.
- es_dest  in  5  EX destination reg; 0 = none/invalid.
- ms_dest  in  5  MEM destination reg; 0 = none/invalid.
- ws_dest  in  5  WB destination reg; 0 = none/invalid.

Behaviour:
- Bundle layout, MSB to LSB: alu_op[11:0] {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}, load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest[4:0], imm[15:0], rs_value[31:0], rt_value[31:0], pc[31:0] = 136 bits.
- Handshake:
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go.
  - On posedge, if ds_allowin: ds_valid <= fs_to_ds_valid.
  - If fs_to_ds_valid && ds_allowin: latch fs_to_ds_bus into ds_instr/ds_pc. Otherwise hold.
- Reset: ds_valid=0, ds_instr=0, ds_pc=0, so ds_to_es_valid=0, jump_bus=0 and ds_allowin=1 on the cycle after reset. Register file contents are not reset; $0 always reads 0. Reset mid-stall discards the held instruction.
- Decode subset: ADDU SUBU SLT SLTU AND OR XOR NOR SLL SRL SRA ADDIU LUI LW SW BEQ BNE JAL JR. Any other opcode decodes as NOP (gr_we=0, mem_we=0, no jump, no hazard check).
- dest:
  - rd for R-type ALU ops.
  - rt for ADDIU/LUI/LW.
  - 31 for JAL.
  - 0 when gr_we=0.
- JAL: src1_is_pc=1, src2_is_8=1, alu add, so the link value is pc+8.
- Register file:
  - 2 combinational read ports (rs, rt); reads of $0 return 0.
  - Write on posedge when rf_we && waddr!=0.
  - No internal bypass; a same-cycle read of the register being written returns the old value. This is safe only because the WB hazard check below stalls that read.
- Hazard stall:
  - ds_ready_go = 0 when ds_valid and an actually-read source (rs and/or rt per instruction) is nonzero and equals es_dest, ms_dest or ws_dest. Otherwise ds_ready_go = 1.
  - Reads: SLL/SRL/SRA read rt only; LUI/JAL read none.
- Branch:
  - taken = ds_valid && ds_ready_go && (BEQ&&rs==rt || BNE&&rs!=rt || JAL || JR).
  - target = BEQ/BNE: ds_pc+4+(sext(imm)<<2). JAL: {ds_pc+4[31:28], instr_index, 2'b00}. JR: rs_value.
  - 32-bit wrap-around, no overflow detect.
  - jump_bus is combinational, so IF consumes it on the same edge ID hands off. The delay-slot instruction already in IF proceeds normally.
  - While stalled, taken=0 and IF is frozen via ds_allowin=0.
- Back-pressure: es_allowin=0 holds the bundle and jump_bus stable. No duplicate or drop is allowed.

Test Plan:
- Reset, then IF sends ADDIU $1,$0,5 at pc 0xbfc00000 -> next cycle ds_to_es_valid=1, dest=1, gr_we=1, src2_is_imm=1, imm=0x0005, pc field 0xbfc00000.
- es_dest=3 while ID holds ADDU $4,$3,$2 -> ds_to_es_valid=0 and ds_allowin=0 until es_dest/ms_dest/ws_dest all differ from 3. Then exactly one issue.
- BEQ $0,$0,+4 at pc 0xbfc00010 -> jump_bus=={1,0xbfc00024} for exactly the handoff cycle. BNE $0,$0 -> taken=0.
- WB writes $5=0xdeadbeef, then JR $5 after ws_dest clears -> target 0xdeadbeef. A write to $0 is ignored and a later read returns 0.
- es_allowin held low 3 cycles with valid LW in ID -> bundle and ds_allowin=0 stable, one transfer on release. Reset asserted mid-hold -> ds_to_es_valid=0 next cycle.
- JAL 0x0100000 at pc 0xbfc00020 -> target 0xb0400000, dest=31, src1_is_pc=1, src2_is_8=1. Undefined opcode -> gr_we=0, mem_we=0, no stall.

Source files
------------

// File: rtl/id_stage.sv
// ID stage of the 5-stage MIPS pipeline: latches {instr, pc} from IF, decodes the
// supported subset, owns the register file, resolves branches and interlocks on RAW hazards.
module id_stage #(
  parameter int FS_TO_DS_BUS_WD = 64,
  parameter int DS_TO_ES_BUS_WD = 136,
  parameter int JUMP_BUS_WD     = 33,
  parameter int WS_TO_RF_BUS_WD = 38
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_allowin,
  output logic [JUMP_BUS_WD-1:0]     jump_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [4:0]                 es_dest,
  input  logic [4:0]                 ms_dest,
  input  logic [4:0]                 ws_dest
);

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_instr_q, ds_instr_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic        ds_ready_go;

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go;

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_instr_d = ds_instr_q;
    ds_pc_d    = ds_pc_q;
    if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        ds_instr_d = fs_to_ds_bus[63:32];
        ds_pc_d    = fs_to_ds_bus[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      ds_instr_q <= 32'd0;
      ds_pc_q    <= 32'd0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_instr_q <= ds_instr_d;
      ds_pc_q    <= ds_pc_d;
    end
  end

  // Register file: no reset, no write-to-read bypass (the WB interlock covers it)
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_q [32];

  assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic [31:0] rs_value, rt_value;

  assign op          = ds_instr_q[31:26];
  assign rs          = ds_instr_q[25:21];
  assign rt          = ds_instr_q[20:16];
  assign rd          = ds_instr_q[15:11];
  assign funct       = ds_instr_q[5:0];
  assign imm         = ds_instr_q[15:0];
  assign instr_index = ds_instr_q[25:0];

  assign rs_value = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_value = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  logic is_special;
  logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
  logic inst_sll, inst_srl, inst_sra, inst_jr;
  logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;

  assign is_special = (op == 6'h00);
  assign inst_addu  = is_special && (funct == 6'h21);
  assign inst_subu  = is_special && (funct == 6'h23);
  assign inst_slt   = is_special && (funct == 6'h2a);
  assign inst_sltu  = is_special && (funct == 6'h2b);
  assign inst_and   = is_special && (funct == 6'h24);
  assign inst_or    = is_special && (funct == 6'h25);
  assign inst_xor   = is_special && (funct == 6'h26);
  assign inst_nor   = is_special && (funct == 6'h27);
  assign inst_sll   = is_special && (funct == 6'h00);
  assign inst_srl   = is_special && (funct == 6'h02);
  assign inst_sra   = is_special && (funct == 6'h03);
  assign inst_jr    = is_special && (funct == 6'h08);
  assign inst_addiu = (op == 6'h09);
  assign inst_lui   = (op == 6'h0f);
  assign inst_lw    = (op == 6'h23);
  assign inst_sw    = (op == 6'h2b);
  assign inst_beq   = (op == 6'h04);
  assign inst_bne   = (op == 6'h05);
  assign inst_jal   = (op == 6'h03);

  logic        r_arith, r_shift;
  logic [11:0] alu_op;
  logic        load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we;
  logic [4:0]  dest;

  assign r_arith = inst_addu | inst_subu | inst_slt | inst_sltu
                 | inst_and  | inst_or   | inst_xor | inst_nor;
  assign r_shift = inst_sll | inst_srl | inst_sra;

  assign alu_op = {inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal,
                   inst_subu, inst_slt, inst_sltu, inst_and, inst_nor, inst_or,
                   inst_xor, inst_sll, inst_srl, inst_sra, inst_lui};

  assign load_op     = inst_lw;
  assign src1_is_sa  = r_shift;
  assign src1_is_pc  = inst_jal;
  assign src2_is_imm = inst_addiu | inst_lui | inst_lw | inst_sw;
  assign src2_is_8   = inst_jal;
  assign gr_we       = r_arith | r_shift | inst_addiu | inst_lui | inst_lw | inst_jal;
  assign mem_we      = inst_sw;

  always_comb begin
    dest = 5'd0;
    if (inst_jal)                                 dest = 5'd31;
    else if (r_arith || r_shift)                  dest = rd;
    else if (inst_addiu || inst_lui || inst_lw)   dest = rt;
  end

  // Only sources the instruction actually consumes take part in the interlock
  logic rs_read, rt_read, rs_hit, rt_hit;

  assign rs_read = r_arith | inst_addiu | inst_lw | inst_sw | inst_beq | inst_bne | inst_jr;
  assign rt_read = r_arith | r_shift | inst_sw | inst_beq | inst_bne;

  assign rs_hit = rs_read && (rs != 5'd0) && ((rs == es_dest) || (rs == ms_dest) || (rs == ws_dest));
  assign rt_hit = rt_read && (rt != 5'd0) && ((rt == es_dest) || (rt == ms_dest) || (rt == ws_dest));

  assign ds_ready_go = !(ds_valid_q && (rs_hit || rt_hit));

  logic [31:0] pc_plus4, br_target, jump_target;
  logic        jump_taken;

  assign pc_plus4  = ds_pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    jump_target = 32'd0;
    if (inst_beq || inst_bne) jump_target = br_target;
    else if (inst_jal)        jump_target = {pc_plus4[31:28], instr_index, 2'b00};
    else if (inst_jr)         jump_target = rs_value;
  end

  assign jump_taken = ds_valid_q && ds_ready_go &&
                      ((inst_beq && (rs_value == rt_value)) ||
                       (inst_bne && (rs_value != rt_value)) ||
                       inst_jal || inst_jr);

  // Target forced to zero when not taken so IF sees an all-zero bus when idle
  assign jump_bus = {jump_taken, jump_taken ? jump_target : 32'd0};

  assign ds_to_es_bus = {alu_op, load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8,
                         gr_we, mem_we, dest, imm, rs_value, rt_value, ds_pc_q};

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random instructions checked against
// a mnemonic-level decode model and a shadow register file.
module tb_id_stage;

  logic         clk;
  logic         reset;
  logic         es_allowin;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_allowin;
  logic [32:0]  jump_bus;
  logic         ds_to_es_valid;
  logic [135:0] ds_to_es_bus;
  logic [37:0]  ws_to_rf_bus;
  logic [4:0]   es_dest, ms_dest, ws_dest;

  int n_total  = 0;
  int n_pass   = 0;
  int handoffs = 0;
  logic [31:0] m_rf [32];

  typedef enum int {I_ADDU, I_SUBU, I_SLT, I_SLTU, I_AND, I_OR, I_XOR, I_NOR,
                    I_SLL, I_SRL, I_SRA, I_ADDIU, I_LUI, I_LW, I_SW,
                    I_BEQ, I_BNE, I_JAL, I_JR, I_UND} mn_t;

  id_stage dut (
    .clk(clk), .reset(reset), .es_allowin(es_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .jump_bus(jump_bus),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .ws_to_rf_bus(ws_to_rf_bus),
    .es_dest(es_dest), .ms_dest(ms_dest), .ws_dest(ws_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && ds_to_es_valid && es_allowin) handoffs++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic mn_t classify(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h21: return I_ADDU;  6'h23: return I_SUBU;  6'h2a: return I_SLT;
        6'h2b: return I_SLTU;  6'h24: return I_AND;   6'h25: return I_OR;
        6'h26: return I_XOR;   6'h27: return I_NOR;   6'h00: return I_SLL;
        6'h02: return I_SRL;   6'h03: return I_SRA;   6'h08: return I_JR;
        default: return I_UND;
      endcase
    end
    case (op)
      6'h09: return I_ADDIU;  6'h0f: return I_LUI;  6'h23: return I_LW;
      6'h2b: return I_SW;     6'h04: return I_BEQ;  6'h05: return I_BNE;
      6'h03: return I_JAL;
      default: return I_UND;
    endcase
  endfunction

  // {reads rs, reads rt}
  function automatic logic [1:0] exp_reads(input logic [31:0] ins);
    case (classify(ins))
      I_ADDU, I_SUBU, I_SLT, I_SLTU, I_AND, I_OR, I_XOR, I_NOR: return 2'b11;
      I_SLL, I_SRL, I_SRA:                                      return 2'b01;
      I_ADDIU, I_LW, I_JR:                                      return 2'b10;
      I_SW, I_BEQ, I_BNE:                                       return 2'b11;
      default:                                                  return 2'b00;
    endcase
  endfunction

  function automatic bit exp_stall(input logic [31:0] ins, input logic [4:0] e,
                                   input logic [4:0] m, input logic [4:0] w);
    logic [1:0] rd;
    logic [4:0] s, t;
    rd = exp_reads(ins);
    s = ins[25:21];
    t = ins[20:16];
    return (rd[1] && s != 0 && (s == e || s == m || s == w)) ||
           (rd[0] && t != 0 && (t == e || t == m || t == w));
  endfunction

  function automatic logic [135:0] exp_bundle(input logic [31:0] ins, input logic [31:0] pc);
    int alu_idx;
    bit ld, sa, p1, im, e8, we, mw;
    logic [4:0] d;
    logic [11:0] onehot, alu;
    alu_idx = -1;
    {ld, sa, p1, im, e8, we, mw} = 7'd0;
    d = 5'd0;
    case (classify(ins))
      I_ADDU:  begin alu_idx = 0;  we = 1; d = ins[15:11]; end
      I_SUBU:  begin alu_idx = 1;  we = 1; d = ins[15:11]; end
      I_SLT:   begin alu_idx = 2;  we = 1; d = ins[15:11]; end
      I_SLTU:  begin alu_idx = 3;  we = 1; d = ins[15:11]; end
      I_AND:   begin alu_idx = 4;  we = 1; d = ins[15:11]; end
      I_NOR:   begin alu_idx = 5;  we = 1; d = ins[15:11]; end
      I_OR:    begin alu_idx = 6;  we = 1; d = ins[15:11]; end
      I_XOR:   begin alu_idx = 7;  we = 1; d = ins[15:11]; end
      I_SLL:   begin alu_idx = 8;  we = 1; sa = 1; d = ins[15:11]; end
      I_SRL:   begin alu_idx = 9;  we = 1; sa = 1; d = ins[15:11]; end
      I_SRA:   begin alu_idx = 10; we = 1; sa = 1; d = ins[15:11]; end
      I_ADDIU: begin alu_idx = 0;  we = 1; im = 1; d = ins[20:16]; end
      I_LUI:   begin alu_idx = 11; we = 1; im = 1; d = ins[20:16]; end
      I_LW:    begin alu_idx = 0;  we = 1; im = 1; ld = 1; d = ins[20:16]; end
      I_SW:    begin alu_idx = 0;  im = 1; mw = 1; end
      I_JAL:   begin alu_idx = 0;  we = 1; p1 = 1; e8 = 1; d = 5'd31; end
      default: ;
    endcase
    onehot = 12'h800;
    alu = (alu_idx < 0) ? 12'd0 : (onehot >> alu_idx);
    return {alu, ld, sa, p1, im, e8, we, mw, d, ins[15:0],
            m_rf[ins[25:21]], m_rf[ins[20:16]], pc};
  endfunction

  function automatic logic [32:0] exp_jump(input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] a, b;
    int off;
    a = m_rf[ins[25:21]];
    b = m_rf[ins[20:16]];
    off = $signed(ins[15:0]);
    case (classify(ins))
      I_BEQ: if (a == b) return {1'b1, pc + 32'd4 + 32'(off * 4)};
      I_BNE: if (a != b) return {1'b1, pc + 32'd4 + 32'(off * 4)};
      I_JAL: return {1'b1, ((pc + 32'd4) & 32'hf000_0000) | ({6'd0, ins[25:0]} << 2)};
      I_JR:  return {1'b1, a};
      default: ;
    endcase
    return 33'd0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd, sa;
    logic [15:0] im;
    logic [5:0] fn, uop;
    int k;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31));
    sa = 5'($urandom);
    im = 16'($urandom);
    if ($urandom_range(0, 3) == 0) rt = rs;
    k = $urandom_range(0, 19);
    case (k)
      1: fn = 6'h23;  2: fn = 6'h2a;  3: fn = 6'h2b;  4: fn = 6'h24;  5: fn = 6'h25;
      6: fn = 6'h26;  7: fn = 6'h27;  8: fn = 6'h00;  9: fn = 6'h02;  10: fn = 6'h03;
      default: fn = 6'h21;
    endcase
    case ($urandom_range(0, 3))
      0: uop = 6'h3f;  1: uop = 6'h08;  2: uop = 6'h20;
      default: uop = 6'h02;
    endcase
    case (k)
      11: return enc_i(6'h09, rs, rt, im);
      12: return enc_i(6'h0f, rs, rt, im);
      13: return enc_i(6'h23, rs, rt, im);
      14: return enc_i(6'h2b, rs, rt, im);
      15: return enc_i(6'h04, rs, rt, im);
      16: return enc_i(6'h05, rs, rt, im);
      17: return enc_j(6'h03, 26'($urandom));
      18: return enc_r(rs, 5'd0, 5'd0, 5'd0, 6'h08);
      19: return enc_i(uop, rs, rt, im);
      default: return enc_r(rs, rt, rd, sa, fn);
    endcase
  endfunction

  function automatic logic [4:0] pick_dest(input logic [4:0] src);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return src;
    if (r == 1) return 5'($urandom_range(0, 31));
    return 5'd0;
  endfunction

  // Presents one instruction; returns at posedge+1 after it was latched
  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {ins, pc};
    @(negedge clk);
    check("load/allowin", ds_allowin, 1);
    step();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    logic [32:0] ej;
    ej = exp_jump(ins, pc);
    check({tag, "/valid"}, ds_to_es_valid, 1);
    check({tag, "/bundle"}, ds_to_es_bus, exp_bundle(ins, pc));
    if (ej[32]) check({tag, "/jump"}, jump_bus, ej);
    else        check({tag, "/taken"}, jump_bus[32], 0);
  endtask

  task automatic check_stall(input string tag);
    check({tag, "/valid"}, ds_to_es_valid, 0);
    check({tag, "/allowin"}, ds_allowin, 0);
    check({tag, "/taken"}, jump_bus[32], 0);
  endtask

  // Called at the negedge where the bundle is offered with es_allowin=1
  task automatic finish_one(input string tag, input int h0);
    step();
    check({tag, "/count"}, handoffs - h0, 1);
    @(negedge clk);
    check({tag, "/drained"}, ds_to_es_valid, 0);
    check({tag, "/jump_idle"}, jump_bus[32], 0);
    step();
  endtask

  initial begin
    logic [31:0] ins, nxt, pc, wd;
    logic [4:0]  wa;
    int h0;
    bit stall;

    reset = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
    ws_to_rf_bus = '0; es_dest = '0; ms_dest = '0; ws_dest = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst/valid", ds_to_es_valid, 0);
    check("rst/jump", jump_bus, 0);
    check("rst/allowin", ds_allowin, 1);
    step();
    reset = 1'b0;

    for (int r = 0; r < 32; r++) begin
      wd = $urandom;
      ws_to_rf_bus = {1'b1, 5'(r), wd};
      if (r != 0) m_rf[r] = wd;
      step();
    end
    ws_to_rf_bus = '0;

    // ADDIU $1,$0,5
    ins = enc_i(6'h09, 5'd0, 5'd1, 16'h0005); pc = 32'hbfc0_0000; h0 = handoffs;
    load(ins, pc);
    @(negedge clk);
    check_issue("addiu", ins, pc);
    check("addiu/dest", ds_to_es_bus[116:112], 1);
    check("addiu/gr_we", ds_to_es_bus[118], 1);
    check("addiu/src2_is_imm", ds_to_es_bus[120], 1);
    check("addiu/imm", ds_to_es_bus[111:96], 16'h0005);
    check("addiu/pc", ds_to_es_bus[31:0], 32'hbfc0_0000);
    finish_one("addiu", h0);

    // ADDU $4,$3,$2 interlocked on $3 walking through EX, MEM, WB
    ins = enc_r(5'd3, 5'd2, 5'd4, 5'd0, 6'h21); pc = 32'hbfc0_0004; h0 = handoffs;
    es_dest = 5'd3;
    load(ins, pc);
    for (int c = 0; c < 3; c++) begin @(negedge clk); check_stall("raw_es"); step(); end
    es_dest = 5'd0; ms_dest = 5'd3;
    for (int c = 0; c < 2; c++) begin @(negedge clk); check_stall("raw_ms"); step(); end
    ms_dest = 5'd0; ws_dest = 5'd3;
    @(negedge clk); check_stall("raw_ws"); step();
    ws_dest = 5'd0; es_dest = 5'd4;
    @(negedge clk);
    check_issue("raw_release", ins, pc);
    finish_one("raw_release", h0);
    es_dest = 5'd0;

    // BEQ $0,$0,+4 taken, BNE $0,$0 not taken
    ins = enc_i(6'h04, 5'd0, 5'd0, 16'h0004); pc = 32'hbfc0_0010; h0 = handoffs;
    load(ins, pc);
    @(negedge clk);
    check("beq/jump", jump_bus, {1'b1, 32'hbfc0_0024});
    check_issue("beq", ins, pc);
    finish_one("beq", h0);
    ins = enc_i(6'h05, 5'd0, 5'd0, 16'h0004); pc = 32'hbfc0_0014; h0 = handoffs;
    load(ins, pc);
    @(negedge clk);
    check("bne/taken", jump_bus[32], 0);
    check_issue("bne", ins, pc);
    finish_one("bne", h0);

    // JR $5 while WB is writing $5
    ins = enc_r(5'd5, 5'd0, 5'd0, 5'd0, 6'h08); pc = 32'hbfc0_0030; h0 = handoffs;
    ws_dest = 5'd5;
    load(ins, pc);
    ws_to_rf_bus = {1'b1, 5'd5, 32'hdead_beef};
    @(negedge clk);
    check_stall("jr_wb");
    step();
    ws_to_rf_bus = '0; ws_dest = 5'd0; m_rf[5] = 32'hdead_beef;
    @(negedge clk);
    check("jr/jump", jump_bus, {1'b1, 32'hdead_beef});
    check_issue("jr", ins, pc);
    finish_one("jr", h0);

    // Write to $0 is dropped
    ws_to_rf_bus = {1'b1, 5'd0, 32'h1234_5678};
    step();
    ws_to_rf_bus = '0;
    ins = enc_r(5'd0, 5'd0, 5'd6, 5'd0, 6'h21); pc = 32'hbfc0_0034; h0 = handoffs;
    load(ins, pc);
    @(negedge clk);
    check("r0/rs_value", ds_to_es_bus[95:64], 0);
    check("r0/rt_value", ds_to_es_bus[63:32], 0);
    check_issue("r0", ins, pc);
    finish_one("r0", h0);

    // LW held by EX back-pressure while IF offers the next instruction
    ins = enc_i(6'h23, 5'd1, 5'd7, 16'h0008); pc = 32'hbfc0_0040; h0 = handoffs;
    es_allowin = 1'b0;
    load(ins, pc);
    nxt = enc_i(6'h09, 5'd2, 5'd8, 16'h0011);
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = {nxt, pc + 32'd4};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp/valid", ds_to_es_valid, 1);
      check("bp/allowin", ds_allowin, 0);
      check("bp/bundle", ds_to_es_bus, exp_bundle(ins, pc));
      step();
    end
    es_allowin = 1'b1;
    @(negedge clk);
    check_issue("bp_release", ins, pc);
    step();
    fs_to_ds_valid = 1'b0;
    check("bp/count", handoffs - h0, 1);
    h0 = handoffs;
    @(negedge clk);
    check_issue("bp_next", nxt, pc + 32'd4);
    finish_one("bp_next", h0);

    // Reset while a held LW is waiting
    es_allowin = 1'b0;
    load(ins, pc);
    @(negedge clk);
    check("rst_hold/valid_before", ds_to_es_valid, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; es_allowin = 1'b1;
    @(negedge clk);
    check("rst_hold/valid", ds_to_es_valid, 0);
    check("rst_hold/allowin", ds_allowin, 1);
    check("rst_hold/jump", jump_bus, 0);
    step();

    // JAL 0x0100000
    ins = enc_j(6'h03, 26'h010_0000); pc = 32'hbfc0_0020; h0 = handoffs;
    load(ins, pc);
    @(negedge clk);
    check("jal/jump", jump_bus, {1'b1, 32'hb040_0000});
    check("jal/dest", ds_to_es_bus[116:112], 31);
    check("jal/src1_is_pc", ds_to_es_bus[121], 1);
    check("jal/src2_is_8", ds_to_es_bus[119], 1);
    check_issue("jal", ins, pc);
    finish_one("jal", h0);

    // Undefined opcode with a matching EX dest must not stall
    ins = enc_i(6'h3f, 5'd3, 5'd3, 16'h1234); pc = 32'hbfc0_0050; h0 = handoffs;
    es_dest = 5'd3;
    load(ins, pc);
    @(negedge clk);
    check("undef/gr_we", ds_to_es_bus[118], 0);
    check("undef/mem_we", ds_to_es_bus[117], 0);
    check_issue("undef", ins, pc);
    finish_one("undef", h0);
    es_dest = 5'd0;

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        wa = 5'($urandom_range(0, 31));
        wd = $urandom;
        ws_to_rf_bus = {1'b1, wa, wd};
        step();
        ws_to_rf_bus = '0;
        if (wa != 5'd0) m_rf[wa] = wd;
      end
      ins = rand_instr();
      pc  = $urandom & 32'hffff_fffc;
      es_dest = pick_dest(ins[25:21]);
      ms_dest = pick_dest(ins[20:16]);
      ws_dest = pick_dest(ins[25:21]);
      stall = exp_stall(ins, es_dest, ms_dest, ws_dest);
      h0 = handoffs;
      load(ins, pc);
      @(negedge clk);
      if (stall) begin
        check_stall("rnd_stall");
        step();
        es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
        @(negedge clk);
      end
      check_issue("rnd", ins, pc);
      finish_one("rnd", h0);
      es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
